// File: rtl/mem_arbiter_ctrl_if.sv
// rtl/mem_arbiter_ctrl_if.sv - request/response and byte-bus bundle for mem_arbiter_ctrl
//
// Groups the fetch port (if_*), the load/store port (ls_*) and the byte-serial
// RAM/IO bus (mem_*). The controller uses the slave modport; requesters and
// the RAM model sit on the master side.
interface mem_arbiter_ctrl_if;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_flush_in;
    logic        if_done_out;
    logic [31:0] if_data_out;

    logic        ls_req_in;
    logic        ls_we_in;
    logic [1:0]  ls_size_in;
    logic [31:0] ls_addr_in;
    logic [31:0] ls_wdata_in;
    logic        ls_done_out;
    logic [31:0] ls_rdata_out;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  if_req_in, if_addr_in, if_flush_in,
        input  ls_req_in, ls_we_in, ls_size_in, ls_addr_in, ls_wdata_in,
        input  mem_din,
        output if_done_out, if_data_out, ls_done_out, ls_rdata_out,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req_in, if_addr_in, if_flush_in,
        output ls_req_in, ls_we_in, ls_size_in, ls_addr_in, ls_wdata_in,
        output mem_din,
        input  if_done_out, if_data_out, ls_done_out, ls_rdata_out,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - IF/LS arbiter, byte-serial RAM/IO sequencer and optional icache
//
// Ports: clk_in (rising edge), rst_n_in (synchronous active-low reset),
//        rdy_in (global enable, low freezes state and masks mem_wr),
//        io_full_in (stalls writes into the IO window),
//        bus (mem_arbiter_ctrl_if.slave: fetch port, load/store port, RAM bus).
// Optional: define ICACHE_EN to build the direct-mapped instruction cache.
module mem_arbiter_ctrl #(
    parameter int          ICACHE_INDEX_LEN = 7,
    parameter logic [31:0] IO_BASE          = 32'h00030000,
    parameter int          IO_SPAN          = 8
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                io_full_in,
    mem_arbiter_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        ls_last;
    logic        if_done_q, ls_done_q, mem_wr_q;
    logic [31:0] if_data_q, ls_rdata_q, mem_a_q, rd_buf;
    logic [7:0]  mem_dout_q;

    function automatic logic in_io(input logic [31:0] a);
        logic [31:0] off;
        off = a - IO_BASE;
        return off < 32'(IO_SPAN);
    endfunction

    logic [2:0]  ls_n, rd_n, wr_c;
    logic [31:0] rd_base, rd_next, wr_a;
    logic [1:0]  cap_idx;
    logic [7:0]  wr_byte;
    logic        wr_stall, wr_done;
    logic        if_valid, ls_valid, grant_if, grant_ls;
    logic        icache_hit;
    logic [31:0] icache_line;

    assign ls_n    = (bus.ls_size_in == 2'd0) ? 3'd1 : (bus.ls_size_in == 2'd1) ? 3'd2 : 3'd4;
    assign rd_n    = (state == IF_READ) ? 3'd4 : ls_n;
    assign rd_base = (state == IF_READ) ? bus.if_addr_in : bus.ls_addr_in;

    // mem_din seen at cnt = k is the byte addressed while cnt was k-1.
    assign cap_idx = 2'(cnt - 3'd1);
    always_comb begin
        rd_next = rd_buf;
        if (cnt != 3'd0) begin
            rd_next[{cap_idx, 3'b000} +: 8] = bus.mem_din;
        end
    end

    // Byte to present next: advance after a committed write, repeat after a stall.
    always_comb begin
        wr_c = 3'd0;
        if (state == LS_WRITE) begin
            wr_c = mem_wr_q ? cnt + 3'd1 : cnt;
        end
    end
    assign wr_a     = bus.ls_addr_in + {29'd0, wr_c};
    assign wr_byte  = bus.ls_wdata_in[{wr_c[1:0], 3'b000} +: 8];
    assign wr_stall = in_io(wr_a) && io_full_in;
    assign wr_done  = (state == LS_WRITE) && mem_wr_q && (cnt == ls_n - 3'd1);

    // A requester still holding req during its own done cycle is not re-served.
    assign if_valid = bus.if_req_in && !if_done_q && !bus.if_flush_in;
    assign ls_valid = bus.ls_req_in && !ls_done_q;
    assign grant_if = if_valid && (!ls_valid || ls_last);
    assign grant_ls = ls_valid && !grant_if;

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_INDEX_LEN;
    localparam int TAG_W = 32 - ICACHE_INDEX_LEN - 2;

    logic [LINES-1:0]            valid;
    logic [TAG_W-1:0]            tag_arr  [LINES];
    logic [31:0]                 data_arr [LINES];
    logic [ICACHE_INDEX_LEN-1:0] if_idx, ls_idx;
    logic [TAG_W-1:0]            if_tag, ls_tag;
    logic                        fill_en, inv_en;

    assign if_idx      = bus.if_addr_in[ICACHE_INDEX_LEN+1:2];
    assign if_tag      = bus.if_addr_in[31:ICACHE_INDEX_LEN+2];
    assign ls_idx      = bus.ls_addr_in[ICACHE_INDEX_LEN+1:2];
    assign ls_tag      = bus.ls_addr_in[31:ICACHE_INDEX_LEN+2];
    assign icache_hit  = valid[if_idx] && (tag_arr[if_idx] == if_tag);
    assign icache_line = data_arr[if_idx];
    assign fill_en     = rdy_in && (state == IF_READ) && !bus.if_flush_in
                         && (cnt == 3'd4) && !in_io(bus.if_addr_in);
    assign inv_en      = rdy_in && wr_done && valid[ls_idx] && (tag_arr[ls_idx] == ls_tag);

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_arr[if_idx]  <= if_tag;
            data_arr[if_idx] <= rd_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[if_idx] <= 1'b1;
        end else if (inv_en) begin
            valid[ls_idx] <= 1'b0;
        end
    end
`else
    assign icache_hit  = 1'b0;
    assign icache_line = '0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            ls_last    <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            mem_wr_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            rd_buf     <= '0;
        end else if (rdy_in) begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        ls_last <= if_valid;
                        cnt     <= 3'd0;
                        if (bus.ls_we_in) begin
                            state      <= LS_WRITE;
                            mem_wr_q   <= !wr_stall;
                            mem_a_q    <= wr_stall ? '0 : wr_a;
                            mem_dout_q <= wr_stall ? '0 : wr_byte;
                        end else begin
                            state   <= LS_READ;
                            mem_a_q <= bus.ls_addr_in;
                            rd_buf  <= '0;
                        end
                    end else if (grant_if) begin
                        ls_last <= 1'b0;
                        if (icache_hit) begin
                            if_done_q <= 1'b1;
                            if_data_q <= icache_line;
                        end else begin
                            state   <= IF_READ;
                            cnt     <= 3'd0;
                            mem_a_q <= bus.if_addr_in;
                            rd_buf  <= '0;
                        end
                    end
                end
                IF_READ, LS_READ: begin
                    if (state == IF_READ && bus.if_flush_in) begin
                        state <= IDLE;
                    end else begin
                        rd_buf <= rd_next;
                        if (cnt == rd_n) begin
                            state <= IDLE;
                            if (state == IF_READ) begin
                                if_done_q <= 1'b1;
                                if_data_q <= rd_next;
                            end else begin
                                ls_done_q  <= 1'b1;
                                ls_rdata_q <= rd_next;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                            if (cnt + 3'd1 < rd_n) begin
                                mem_a_q <= rd_base + {29'd0, cnt + 3'd1};
                            end
                        end
                    end
                end
                LS_WRITE: begin
                    if (wr_done) begin
                        state     <= IDLE;
                        ls_done_q <= 1'b1;
                        mem_wr_q  <= 1'b0;
                    end else begin
                        cnt        <= wr_c;
                        mem_wr_q   <= !wr_stall;
                        mem_a_q    <= wr_stall ? '0 : wr_a;
                        mem_dout_q <= wr_stall ? '0 : wr_byte;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_done_out  = if_done_q;
    assign bus.if_data_out  = if_data_q;
    assign bus.ls_done_out  = ls_done_q;
    assign bus.ls_rdata_out = ls_rdata_q;
    assign bus.mem_wr       = mem_wr_q & rdy_in;
    assign bus.mem_a        = mem_a_q;
    assign bus.mem_dout     = mem_dout_q;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb/tb_mem_arbiter_ctrl.sv - directed scoreboard bench for mem_arbiter_ctrl
module tb_mem_arbiter_ctrl;
`ifdef ICACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 6;
`endif

    logic clk_in = 1'b0;
    logic rst_n_in, rdy_in, io_full_in;
    logic ram_init;

    mem_arbiter_ctrl_if bus ();

    mem_arbiter_ctrl dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rdy_in     (rdy_in),
        .io_full_in (io_full_in),
        .bus        (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        is_ls;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   if_done_cnt = 0;
    int   ls_done_cnt = 0;
    int   io_cnt = 0;
    logic [7:0] io_byte;
    logic [7:0] ram [0:4095];

    function automatic logic is_io(input logic [31:0] a);
        return (a >= 32'h00030000) && (a < 32'h00030008);
    endfunction

    // Byte RAM with one-cycle read latency; IO-window writes are logged instead.
    always @(posedge clk_in) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h004] <= 8'h13; ram[12'h005] <= 8'h05;
            ram[12'h008] <= 8'h93; ram[12'h00A] <= 8'h10;
            ram[12'h100] <= 8'hEF; ram[12'h101] <= 8'hBE;
            ram[12'h102] <= 8'hAD; ram[12'h103] <= 8'hDE;
            ram[12'h200] <= 8'h13;
            ram[12'h300] <= 8'h6F;
        end else if (bus.mem_wr) begin
            if (is_io(bus.mem_a)) begin
                io_cnt  <= io_cnt + 1;
                io_byte <= bus.mem_dout;
            end else begin
                ram[bus.mem_a[11:0]] <= bus.mem_dout;
            end
        end
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input logic is_ls, input logic [31:0] obs);
        exp_t e;
        check(is_ls ? "sb_ls_expected" : "sb_if_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_order", {31'd0, is_ls}, {31'd0, e.is_ls});
            if (e.chk) check(is_ls ? "ls_rdata" : "if_data", obs, e.data);
        end
    endtask

    always @(negedge clk_in) begin
        if (bus.if_done_out === 1'b1) begin
            if_done_cnt++;
            sb_pop(1'b0, bus.if_data_out);
        end
        if (bus.ls_done_out === 1'b1) begin
            ls_done_cnt++;
            sb_pop(1'b1, bus.ls_rdata_out);
        end
    end

    task automatic wait_evt(input logic is_ls, output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if ((is_ls ? bus.ls_done_out : bus.if_done_out) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic gap();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_if(input logic [31:0] addr, input logic [31:0] data, input int lat);
        int n;
        exp_q.push_back({1'b0, 1'b1, data});
        bus.if_addr_in = addr;
        bus.if_req_in  = 1'b1;
        wait_evt(1'b0, n);
        bus.if_req_in  = 1'b0;
        check("if_latency", n, lat);
        gap();
    endtask

    task automatic do_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] data, input int lat);
        int n;
        exp_q.push_back({1'b1, !we, data});
        bus.ls_we_in    = we;
        bus.ls_size_in  = size;
        bus.ls_addr_in  = addr;
        bus.ls_wdata_in = wdata;
        bus.ls_req_in   = 1'b1;
        wait_evt(1'b1, n);
        bus.ls_req_in   = 1'b0;
        check("ls_latency", n, lat);
        gap();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_if_done"},  {31'd0, bus.if_done_out}, 32'd0);
        check({tag, "_ls_done"},  {31'd0, bus.ls_done_out}, 32'd0);
        check({tag, "_if_data"},  bus.if_data_out, 32'd0);
        check({tag, "_ls_rdata"}, bus.ls_rdata_out, 32'd0);
        check({tag, "_mem_wr"},   {31'd0, bus.mem_wr}, 32'd0);
        check({tag, "_mem_a"},    bus.mem_a, 32'd0);
        check({tag, "_mem_dout"}, {24'd0, bus.mem_dout}, 32'd0);
    endtask

    initial begin
        int t_ls1, t_if, t_ls2, c0, n;
        rst_n_in = 1'b0; rdy_in = 1'b1; io_full_in = 1'b0; ram_init = 1'b1;
        bus.if_req_in = 1'b0; bus.if_addr_in = '0; bus.if_flush_in = 1'b0;
        bus.ls_req_in = 1'b0; bus.ls_we_in = 1'b0; bus.ls_size_in = '0;
        bus.ls_addr_in = '0; bus.ls_wdata_in = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        ram_init = 1'b0;
        check_zero_outputs("reset");
        rst_n_in = 1'b1;
        gap();

        // cold fetch, then refetch
        do_if(32'h0000_0004, 32'h0000_0513, 6);
        do_if(32'h0000_0004, 32'h0000_0513, HIT_LAT);

        // LS and IF together: LS, then IF, then the held LS again
        exp_q.push_back({1'b1, 1'b1, 32'hDEADBEEF});
        exp_q.push_back({1'b0, 1'b1, 32'h0010_0093});
        exp_q.push_back({1'b1, 1'b1, 32'hDEADBEEF});
        bus.ls_we_in = 1'b0; bus.ls_size_in = 2'd2; bus.ls_addr_in = 32'h100;
        bus.if_addr_in = 32'h8;
        bus.ls_req_in = 1'b1; bus.if_req_in = 1'b1;
        t_ls1 = 0; t_if = 0; t_ls2 = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (bus.ls_done_out === 1'b1) begin
                if (t_ls1 == 0) t_ls1 = i;
                else begin
                    t_ls2 = i;
                    bus.ls_req_in = 1'b0;
                    break;
                end
            end
            if (bus.if_done_out === 1'b1) begin
                t_if = i;
                bus.if_req_in = 1'b0;
            end
        end
        bus.ls_req_in = 1'b0; bus.if_req_in = 1'b0;
        check("arb_ls_first", t_ls1, 6);
        check("arb_if_next", t_if, 12);
        check("arb_ls_again", t_ls2, 18);
        gap();

        // load sizes, size 3 treated as word
        do_ls(1'b0, 2'd1, 32'h102, 32'h0, 32'h0000_DEAD, 4);
        do_ls(1'b0, 2'd0, 32'h101, 32'h0, 32'h0000_00BE, 3);
        do_ls(1'b0, 2'd3, 32'h100, 32'h0, 32'hDEAD_BEEF, 6);

        // IO back-pressure on a console byte store
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        io_full_in = 1'b1;
        bus.ls_we_in = 1'b1; bus.ls_size_in = 2'd0;
        bus.ls_addr_in = 32'h0003_0000; bus.ls_wdata_in = 32'h41;
        bus.ls_req_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check("io_stall_wr", {31'd0, bus.mem_wr}, 32'd0);
            check("io_stall_a", bus.mem_a, 32'd0);
        end
        io_full_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check("io_wr", {31'd0, bus.mem_wr}, 32'd1);
        check("io_a", bus.mem_a, 32'h0003_0000);
        check("io_dout", {24'd0, bus.mem_dout}, 32'h41);
        wait_evt(1'b1, n);
        bus.ls_req_in = 1'b0;
        check("io_done_lat", n, 1);
        check("io_write_count", io_cnt, 1);
        check("io_write_byte", {24'd0, io_byte}, 32'h41);
        gap();

        // flush in the middle of a miss
        c0 = if_done_cnt;
        bus.if_addr_in = 32'h300; bus.if_req_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        bus.if_flush_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.if_flush_in = 1'b0; bus.if_req_in = 1'b0;
        repeat (8) @(posedge clk_in);
        @(negedge clk_in);
        check("flush_no_done", if_done_cnt - c0, 0);
        do_if(32'h300, 32'h0000_006F, 6);

        // rdy low freezes a store and masks mem_wr
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        bus.ls_we_in = 1'b1; bus.ls_size_in = 2'd2;
        bus.ls_addr_in = 32'h180; bus.ls_wdata_in = 32'h5566_7788;
        bus.ls_req_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        #1;
        check("rdy_low_wr", {31'd0, bus.mem_wr}, 32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b1;
        wait_evt(1'b1, n);
        bus.ls_req_in = 1'b0;
        check("rdy_store_lat", n, 4);
        gap();
        do_ls(1'b0, 2'd2, 32'h180, 32'h0, 32'h5566_7788, 6);

        // store invalidates a cached line
        do_if(32'h200, 32'h0000_0013, 6);
        do_if(32'h200, 32'h0000_0013, HIT_LAT);
        do_ls(1'b1, 2'd2, 32'h200, 32'h0010_0073, 32'h0, 5);
        do_if(32'h200, 32'h0010_0073, 6);

        // reset in the middle of a store
        c0 = ls_done_cnt;
        bus.ls_we_in = 1'b1; bus.ls_size_in = 2'd2;
        bus.ls_addr_in = 32'h280; bus.ls_wdata_in = 32'h1122_3344;
        bus.ls_req_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        bus.ls_req_in = 1'b0;
        check_zero_outputs("midreset");
        rst_n_in = 1'b1;
        repeat (6) @(posedge clk_in);
        @(negedge clk_in);
        check("midreset_no_done", ls_done_cnt - c0, 0);
        do_if(32'h0000_0004, 32'h0000_0513, 6);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Second-generation memory controller between instruction fetch (IF), load/store buffer (LS) and the byte-serial unified RAM/IO bus.
- Arbitrates two request ports with explicit req/done handshakes.
- Serialises 1/2/4-byte accesses onto the 8-bit RAM port and applies IO back-pressure on console writes.
- Serves fetches from a parametrised direct-mapped icache, with IF flush and store-driven icache invalidation.

Parameters:
ICACHE_INDEX_LEN, 7, log2 of icache lines; one 32-bit word per line, index = if_addr_in[ICACHE_INDEX_LEN+1:2].
IO_BASE, 32'h00030000, first byte address of the IO window.
IO_SPAN, 8, IO window size in bytes; IO addresses are never cached.

Ports:
clk_in  input  1  clock, all state on rising edge
rst_n_in  input  1  synchronous active-low reset
rdy_in  input  1  global enable; low freezes all state
io_full_in  input  1  UART buffer full; stalls IO-window writes
if_req_in  input  1  fetch request; held with if_addr_in until if_done_out
if_addr_in  input  32  fetch address, word aligned
if_flush_in  input  1  abort any fetch in flight (mispredict)
if_done_out  output  1  one-cycle pulse; if_data_out valid
if_data_out  output  32  fetched instruction
ls_req_in  input  1  load/store request; fields held until ls_done_out
ls_we_in  input  1  1 = store, 0 = load
ls_size_in  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
ls_addr_in  input  32  byte address
ls_wdata_in  input  32  store data, little-endian, low bytes used
ls_done_out  output  1  one-cycle pulse
ls_rdata_out  output  32  load data, zero-extended; the LSB sign-extends
mem_din  input  8  RAM read data, one cycle after address
mem_dout  output  8  RAM write byte
mem_a  output  32  RAM byte address
mem_wr  output  1  1 = write, 0 = read

Behaviour:
- Reset (rst_n_in low at edge):
  - state = IDLE, all counters 0, all icache valid bits cleared.
  - if_done_out = 0, ls_done_out = 0, if_data_out = 0, ls_rdata_out = 0.
  - mem_wr = 0, mem_a = 0, mem_dout = 0.
  - Reset mid-transfer abandons it; no done pulse is produced.
- rdy_in low: registers hold and mem_wr is forced to 0.
- States:
  - IDLE; IF_READ; LS_READ; LS_WRITE.
  - N = 1/2/4 bytes from ls_size_in (IF always 4).
  - cnt is a 3-bit byte counter.
- IDLE arbitration, evaluated every edge:
  - A req whose done pulse is high this cycle is ignored.
  - ls_req_in beats if_req_in. On a tie, IF is served next free cycle, so LS cannot take two consecutive grants while IF waits: fairness bit toggles on each LS grant.
  - IF with icache hit: if_data_out = line, if_done_out = 1 at the same edge, state stays IDLE. Latency is 1 edge.
  - IF miss: go to IF_READ, cnt = 0.
  - LS load: go to LS_READ. LS store: go to LS_WRITE.
- IF_READ / LS_READ:
  - mem_a = addr + cnt while cnt < N, otherwise mem_a holds the last address.
  - At cnt = k (1..N), byte k-1 is captured from mem_din.
  - At cnt = N: done pulse, data out, return to IDLE.
  - Latency is N+2 edges from grant-sampling edge to done (word = 6).
  - IO-window reads are never stalled.
- LS_WRITE:
  - Drive mem_wr = 1, mem_a = addr + cnt, mem_dout = byte cnt.
  - Done at the edge ending cnt = N-1. Latency is N+1 edges.
  - IO-window address with io_full_in = 1: drive mem_wr = 0, mem_a = 0, cnt holds; resume when io_full_in falls.
- IF fill: at IF_READ completion, line is written valid with tag if_addr_in[31:ICACHE_INDEX_LEN+2], unless the address is in the IO window.
- Flush:
  - if_flush_in high at any edge in IF_READ: return to IDLE, no if_done_out, no fill.
  - In IDLE, flush suppresses a same-cycle hit pulse.
  - Flush never affects LS states.
- Store invalidation: on LS_WRITE completion, if the icache line indexed by ls_addr_in holds a matching tag, clear its valid bit (self-modifying code).
- Simultaneous events:
  - Fill and invalidation never coincide (single FSM).
  - Flush together with if_req_in in IDLE: request ignored that edge.

Optional Feature:
ICACHE_EN:
- Defined: icache arrays present, hits served in 1 edge, fill and invalidation as above.
- Undefined: no arrays, every fetch takes IF_READ (6 edges), and the store-invalidation logic is absent.

Test Plan:
- Cold fetch 0x00000004, RAM bytes 13 05 00 00 -> if_done_out after 6 edges, if_data_out = 32'h00000513. Refetch -> done after 1 edge (ICACHE_EN).
- Simultaneous ls_req_in (load word 0x100 = 32'hDEADBEEF) and if_req_in (miss) -> LS granted first, ls_rdata_out = 32'hDEADBEEF after 6 edges; IF granted next, no second LS grant while IF waits.
- Byte store 0x41 to 0x30000 with io_full_in high 3 cycles -> mem_wr = 0, mem_a = 0 for 3 cycles, then one write of 0x41, ls_done_out one edge later.
- IF miss in progress, if_flush_in at cnt = 2 -> no if_done_out, IDLE next edge; refetch of the same address misses again (takes 6 edges).
- Fetch 0x200 (cached), then word store 32'h00100073 to 0x200, then fetch 0x200 -> miss, RAM path, if_data_out = 32'h00100073.
- rst_n_in low during LS_WRITE cnt = 1 -> all outputs 0 next edge, no ls_done_out, icache empty (next fetch misses).
